hm_dispatcher: RTL
==================

# hm_dispatcher

Job-side initiator for a bank of hashing modules. Latches one 512-bit block and 256-bit difficulty target from the host and broadcasts them to `NUM_HM` hashing modules. Pulses `begin_hash` to all of them, monitors each module's `hash_done`/`valid_hash_flag`, and captures the first winning hash and nonce. On a win or an abort it pulses `quit_hash` to the whole bank, then presents the result to the host with a valid/ack handshake.

## Interface
- `NUM_HM`, 4: number of hashing modules driven (1..16).
- `WATCHDOG_CYCLES`, 32'd1000000: WAIT-state cycle budget; used only with `HM_WATCHDOG_EN`.

- `clk` in 1: system clock.
- `n_rst` in 1: reset, synchronous, active-low.
- `job_start` in 1: host request; sampled only in IDLE.
- `job_data` in 512: block to hash; latched with `job_start`.
- `job_difficulty` in 256: target; latched with `job_start`.
- `job_abort` in 1: host cancel; honoured in WAIT only.
- `result_ack` in 1: host consumed result; honoured in DONE only.
- `hash_done` in NUM_HM: per-module completion.
- `valid_hash_flag` in NUM_HM: per-module "hash meets difficulty".
- `valid_hash` in NUM_HM*288: module i occupies bits [288*i+287 : 288*i]. Within each slice, [287:256] is the nonce and [255:0] is the hash.
- `data_to_hash` out 512: registered broadcast copy of `job_data`.
- `difficulty` out 256: registered broadcast copy of `job_difficulty`.
- `begin_hash` out NUM_HM: start pulse, all bits together.
- `quit_hash` out NUM_HM: stop pulse, all bits together.
- `busy` out 1: state != IDLE.
- `result_valid` out 1: result registers valid.
- `result_found` out 1: 1 means a hash was found; 0 means the nonce space was exhausted or the watchdog expired.
- `result_timeout` out 1: watchdog expired.
- `result_module` out 4: index of the winning module.
- `result_nonce` out 32, `result_hash` out 256: captured winner.

## Operation
- States: IDLE, LAUNCH, WAIT, ABORT, DONE.
- **IDLE**
  - With `job_start`=1: latch data and difficulty into `data_to_hash`/`difficulty`, clear `done_mask`, clear all result registers, and go to LAUNCH.
  - `job_start` in any other state is ignored.
- **LAUNCH**: `begin_hash` = all ones for exactly this cycle, then go to WAIT.
- **WAIT**: every cycle, form `win = hash_done & valid_hash_flag`.
  - If `win` is nonzero: take the lowest set index i, capture slice i into `result_hash`/`result_nonce`, set `result_module`=i and `result_found`=1, and go to ABORT.
  - Otherwise: `done_mask |= hash_done`.
    - If the updated `done_mask` is all ones, go to DONE with `result_found`=0. No quit is needed because every module has finished.
    - Otherwise, if `job_abort`=1, go to ABORT with `result_found`=0 and mark the job as aborted.
  - A win takes priority over `job_abort` and over exhaustion when they occur in the same cycle.
- **ABORT**: `quit_hash` = all ones for exactly this cycle.
  - After a host abort, go to IDLE; no `result_valid` is raised.
  - Otherwise, go to DONE.
- **DONE**: `result_valid`=1. All result outputs stay stable until `result_ack`=1, then go to IDLE.
  - `result_valid` drops in the IDLE cycle.
  - Result registers hold their values until the next `job_start`.
- `data_to_hash`/`difficulty` stay constant from LAUNCH until the next accepted `job_start`.
- `hash_done`/`valid_hash_flag` are ignored outside WAIT.
- Reset (`n_rst`=0 at a clock edge), in any state:
  - State goes to IDLE.
  - Every output goes to 0, including `data_to_hash`, `difficulty`, and all result fields.
  - `done_mask` is cleared.
  - Reset mid-job does not pulse `quit_hash`; the modules share the same reset.

## Timing
- `job_start` sampled at edge T: LAUNCH during cycle T+1 with `begin_hash` high and broadcast data valid. WAIT begins at T+2.
- Win sampled at edge W:
  - ABORT during W+1: `quit_hash` high, and result fields already valid on the outputs.
  - DONE from W+2: `result_valid` high.
- Exhaustion sampled at edge W: DONE from W+1 with no quit pulse.
- `result_ack` sampled at edge A while in DONE: IDLE from A+1. `job_start` is accepted at A+1 at the earliest.
- Minimum job-to-job spacing is 5 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `HM_WATCHDOG_EN` defined:
  - A 32-bit counter clears on LAUNCH and increments each WAIT cycle.
  - When it equals `WATCHDOG_CYCLES-1` and there is no win that cycle: set `result_timeout`=1 and `result_found`=0, then go through ABORT (quit pulse) to DONE.
  - Priority order in the same cycle: win, then exhaustion, then host abort, then watchdog.
- Undefined: no counter is built, `result_timeout` is tied to 0, and WAIT never times out.

## Test plan
- Reset, then `job_start` with data=512'hA5.., difficulty=256'h0000FFFF.. -> `begin_hash`=4'b1111 for exactly cycle T+1, and `data_to_hash`/`difficulty` equal the inputs.
- Module 2 raises `hash_done`+`valid_hash_flag` with nonce 32'h0000_1234 -> `quit_hash`=4'b1111 for one cycle, then `result_valid`=1, `result_found`=1, `result_module`=2, `result_nonce`=32'h1234. Outputs hold until `result_ack`; `busy`=0 one cycle after ack.
- Modules 1 and 3 win in the same cycle -> `result_module`=1.
- Modules finish without a valid hash on different cycles (0, then 3, then 1 and 2 together) -> DONE with `result_found`=0 and no `quit_hash` pulse.
- `job_abort` in WAIT -> one `quit_hash` pulse, return to IDLE, `result_valid` never rises. Repeat with a win on the same edge as the abort -> a normal found result.
- With `HM_WATCHDOG_EN` and `WATCHDOG_CYCLES`=20, no module responds -> quit pulse 20 cycles after WAIT entry, then `result_timeout`=1. Assert `n_rst`=0 during WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hm_dispatcher.sv
// hm_dispatcher: job-side initiator for a bank of NUM_HM hashing modules.
// Latches one block and difficulty target, broadcasts them, pulses
// begin_hash, watches for the first winning module, pulses quit_hash on a
// win or host abort, and hands the captured result to the host with a
// valid/ack handshake.
// Optional feature: define HM_WATCHDOG_EN to build a WAIT-state watchdog
// that gives up after WATCHDOG_CYCLES cycles; without it result_timeout is 0.
module hm_dispatcher #(
  parameter int          NUM_HM          = 4,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd1000000
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  job_start,
  input  logic [511:0]          job_data,
  input  logic [255:0]          job_difficulty,
  input  logic                  job_abort,
  input  logic                  result_ack,
  input  logic [NUM_HM-1:0]     hash_done,
  input  logic [NUM_HM-1:0]     valid_hash_flag,
  input  logic [NUM_HM*288-1:0] valid_hash,
  output logic [511:0]          data_to_hash,
  output logic [255:0]          difficulty,
  output logic [NUM_HM-1:0]     begin_hash,
  output logic [NUM_HM-1:0]     quit_hash,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  result_found,
  output logic                  result_timeout,
  output logic [3:0]            result_module,
  output logic [31:0]           result_nonce,
  output logic [255:0]          result_hash
);

  // Elaboration-time guard on parameter ranges.
  if (NUM_HM < 1 || NUM_HM > 16 || WATCHDOG_CYCLES == 32'd0) begin : g_param_check
    $error("hm_dispatcher: NUM_HM must be 1..16 and WATCHDOG_CYCLES nonzero");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    ABORT  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [511:0]        data_q, data_d;
  logic [255:0]        diff_q, diff_d;
  logic [NUM_HM-1:0]   done_mask_q, done_mask_d;
  logic [NUM_HM-1:0]   begin_hash_q, begin_hash_d;
  logic [NUM_HM-1:0]   quit_hash_q, quit_hash_d;
  logic                busy_q, busy_d;
  logic                aborted_q, aborted_d;
  logic                result_valid_q, result_valid_d;
  logic                result_found_q, result_found_d;
  logic [3:0]          result_module_q, result_module_d;
  logic [31:0]         result_nonce_q, result_nonce_d;
  logic [255:0]        result_hash_q, result_hash_d;

  logic [NUM_HM-1:0]   win;
  logic [3:0]          win_idx;
  logic [287:0]        win_slice;

`ifdef HM_WATCHDOG_EN
  logic [31:0]         wd_cnt_q, wd_cnt_d;
  logic                result_timeout_q, result_timeout_d;
  logic [31:0]         wd_last;
  assign wd_last = WATCHDOG_CYCLES - 32'd1;
`endif

  // Lowest-index winner select: scan high to low so the lowest set bit wins.
  always_comb begin
    win       = hash_done & valid_hash_flag;
    win_idx   = '0;
    win_slice = '0;
    for (int i = NUM_HM - 1; i >= 0; i--) begin
      if (win[i]) begin
        win_idx   = 4'(i);
        win_slice = valid_hash[288*i +: 288];
      end
    end
  end

  // Next-state and next-register logic for the job FSM.
  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    diff_d          = diff_q;
    done_mask_d     = done_mask_q;
    aborted_d       = aborted_q;
    result_found_d  = result_found_q;
    result_module_d = result_module_q;
    result_nonce_d  = result_nonce_q;
    result_hash_d   = result_hash_q;
`ifdef HM_WATCHDOG_EN
    wd_cnt_d         = wd_cnt_q;
    result_timeout_d = result_timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (job_start) begin
          data_d          = job_data;
          diff_d          = job_difficulty;
          done_mask_d     = '0;
          aborted_d       = 1'b0;
          result_found_d  = 1'b0;
          result_module_d = '0;
          result_nonce_d  = '0;
          result_hash_d   = '0;
`ifdef HM_WATCHDOG_EN
          result_timeout_d = 1'b0;
`endif
          state_d         = LAUNCH;
        end
      end

      LAUNCH: begin
`ifdef HM_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
        if (|win) begin
          // A win beats exhaustion, host abort and watchdog in the same cycle.
          result_found_d  = 1'b1;
          result_module_d = win_idx;
          result_nonce_d  = win_slice[287:256];
          result_hash_d   = win_slice[255:0];
          state_d         = ABORT;
        end else begin
          done_mask_d = done_mask_q | hash_done;
          if (&done_mask_d) begin
            // Every module already stopped, so no quit pulse is needed.
            result_found_d = 1'b0;
            state_d        = DONE;
          end else if (job_abort) begin
            result_found_d = 1'b0;
            aborted_d      = 1'b1;
            state_d        = ABORT;
          end
`ifdef HM_WATCHDOG_EN
          else if (wd_cnt_q == wd_last) begin
            result_found_d   = 1'b0;
            result_timeout_d = 1'b1;
            state_d          = ABORT;
          end else begin
            wd_cnt_d = wd_cnt_q + 32'd1;
          end
`endif
        end
      end

      ABORT: begin
        // A host-cancelled job returns silently; others report a result.
        state_d = aborted_q ? IDLE : DONE;
      end

      DONE: begin
        if (result_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pulse and status outputs are registered from the next state so they
    // line up with the state they describe.
    begin_hash_d   = (state_d == LAUNCH) ? '1 : '0;
    quit_hash_d    = (state_d == ABORT)  ? '1 : '0;
    busy_d         = (state_d != IDLE);
    result_valid_d = (state_d == DONE);
  end

  // State and output registers; reset clears everything, data included.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      data_q          <= '0;
      diff_q          <= '0;
      done_mask_q     <= '0;
      begin_hash_q    <= '0;
      quit_hash_q     <= '0;
      busy_q          <= 1'b0;
      aborted_q       <= 1'b0;
      result_valid_q  <= 1'b0;
      result_found_q  <= 1'b0;
      result_module_q <= '0;
      result_nonce_q  <= '0;
      result_hash_q   <= '0;
    end else begin
      state_q         <= state_d;
      data_q          <= data_d;
      diff_q          <= diff_d;
      done_mask_q     <= done_mask_d;
      begin_hash_q    <= begin_hash_d;
      quit_hash_q     <= quit_hash_d;
      busy_q          <= busy_d;
      aborted_q       <= aborted_d;
      result_valid_q  <= result_valid_d;
      result_found_q  <= result_found_d;
      result_module_q <= result_module_d;
      result_nonce_q  <= result_nonce_d;
      result_hash_q   <= result_hash_d;
    end
  end

`ifdef HM_WATCHDOG_EN
  // Watchdog counter and timeout flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wd_cnt_q         <= '0;
      result_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q         <= wd_cnt_d;
      result_timeout_q <= result_timeout_d;
    end
  end

  assign result_timeout = result_timeout_q;
`else
  assign result_timeout = 1'b0;
`endif

  assign data_to_hash  = data_q;
  assign difficulty    = diff_q;
  assign begin_hash    = begin_hash_q;
  assign quit_hash     = quit_hash_q;
  assign busy          = busy_q;
  assign result_valid  = result_valid_q;
  assign result_found  = result_found_q;
  assign result_module = result_module_q;
  assign result_nonce  = result_nonce_q;
  assign result_hash   = result_hash_q;

endmodule
